gshare_predictor: RTL and testbench
===================================

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 Parameter XLEN, default 32, datapath and PC width.
REQ-002 Parameter IDX_BITS, default 5, BTB/BHT index width; table depth is 2^IDX_BITS.
REQ-003 Parameter GHR_BITS, default 5, global history width; GHR_BITS SHALL be <= IDX_BITS.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 lookup_valid  in  1  IF stage advances this cycle (low while PC/IF-ID are stalled).
REQ-007 lookup_pc  in  XLEN  current IF-stage PC.
REQ-008 pred_taken  out  1  predicted taken for lookup_pc.
REQ-009 pred_target  out  XLEN  predicted next PC.
REQ-010 lookup_ghr  out  GHR_BITS  speculative GHR snapshot; carried down the pipeline with the instruction.
REQ-011 update_valid  in  1  a resolved branch/jump reports from EX.
REQ-012 update_pc  in  XLEN  PC of the resolved instruction.
REQ-013 update_ghr  in  GHR_BITS  GHR snapshot the resolved instruction was predicted with.
REQ-014 update_taken  in  1  actual outcome (1 for unconditional jumps).
REQ-015 update_target  in  XLEN  actual target address.
REQ-016 update_mispredict  in  1  outcome or target differed from prediction; qualified by update_valid.

Function
REQ-017 BTB index = pc[IDX_BITS+1:2]; tag = pc[XLEN-1:IDX_BITS+2]; each entry holds valid, tag, target.
REQ-018 BHT index = pc[IDX_BITS+1:2] XOR zero-extended GHR; each entry is a 2-bit saturating counter (0 SNT, 1 WNT, 2 WT, 3 ST).
REQ-019 Lookup is combinational: hit = valid && tag match; pred_taken = hit && counter[1], counter indexed with the current speculative GHR.
REQ-020 pred_target = BTB target when pred_taken, else lookup_pc + 4 (modulo 2^XLEN).
REQ-021 lookup_ghr SHALL equal the speculative GHR register value in the same cycle.
REQ-022 Speculative GHR update: when lookup_valid && hit, GHR <= {GHR[GHR_BITS-2:0], pred_taken}; otherwise hold.
REQ-023 Recovery: when update_valid && update_mispredict, GHR <= {update_ghr[GHR_BITS-2:0], update_taken}; this has priority over REQ-022 in the same cycle.
REQ-024 Training: when update_valid, BHT[update_pc index XOR update_ghr] increments if update_taken and decrements otherwise, saturating at 3 and 0.
REQ-025 When update_valid && update_taken, BTB[update_pc index] <= {valid=1, tag of update_pc, update_target}, replacing any prior entry; not-taken updates leave the BTB unchanged.
REQ-026 update_valid low SHALL leave the BTB, BHT and GHR (except through REQ-022) unchanged.
REQ-027 A lookup and an update to the same entry in the same cycle: the lookup sees the pre-update contents, and the new contents are visible from the next cycle.
REQ-028 Latency: a training update is visible to lookups one cycle after update_valid.

Reset
REQ-029 While reset is low: all BTB valid bits 0, all BHT counters 1 (WNT), GHR 0; takes effect immediately, independent of clk.
REQ-030 During and after reset, pred_taken = 0, pred_target = lookup_pc + 4, and lookup_ghr = 0.
REQ-031 Reset asserted mid-operation discards all learned state, and no partial update survives.

Structure
REQ-032 A shared package SHALL hold the default parameter values and the counter encoding constants SNT/WNT/WT/ST.
REQ-033 One sub-module, sat_counter2 (2-bit saturating next-state logic), SHALL be instantiated for the BHT update path.
REQ-034 BTB and BHT are register arrays; no memory macros are used.

Verification
REQ-035 Reset, then lookup_pc=0x100 -> pred_taken=0, pred_target=0x104, lookup_ghr=0.
REQ-036 Update pc=0x100, taken, target=0x40, ghr=0, mispredict=1; next cycle GHR=00001; lookup 0x100 with GHR=1 indexes counter (0 XOR 1), which is still WNT -> pred_taken=0, pred_target=0x104.
REQ-037 Three taken updates at pc=0x100 with ghr=0, then a further taken update -> counter saturates at 3 with no wrap to 0; a single not-taken update -> 2, and the prediction is still taken.
REQ-038 Lookup of 0x100 hit and predicted taken, with lookup_valid=1 and update_mispredict=1 (update_ghr=00110, taken=0) in the same cycle -> GHR=01100 next cycle (recovery wins).
REQ-039 Aliasing: BTB holds 0x100; lookup 0x1100 (same index, different tag) -> miss, pred_target=0x1104, GHR unchanged with lookup_valid=1.
REQ-040 Reset pulsed low asynchronously between clock edges after training -> pred_taken drops to 0 immediately, and all entries are invalid afterwards.

Source files
------------

// File: rtl/gshare_predictor_pkg.sv
// gshare_predictor_pkg
//   Shared definitions for the gshare branch predictor.
//   - Default values for the XLEN, IDX_BITS and GHR_BITS parameters.
//   - The encoding of the 2-bit saturating direction counter
//     (SNT/WNT/WT/ST). Bit 1 of a counter is its taken prediction.
package gshare_predictor_pkg;

   localparam int unsigned XLEN_DEFAULT     = 32;
   localparam int unsigned IDX_BITS_DEFAULT = 5;
   localparam int unsigned GHR_BITS_DEFAULT = 5;

   typedef enum logic [1:0] {
      SNT = 2'd0,
      WNT = 2'd1,
      WT  = 2'd2,
      ST  = 2'd3
   } ctr_state_e;

endpackage

// File: rtl/sat_counter2.sv
// sat_counter2
//   Next-state logic for a 2-bit saturating counter. The count moves up
//   toward ST when inc is high and down toward SNT when inc is low. It
//   holds at either end and never wraps.
// Ports:
//   cnt      in  2  current counter value
//   inc      in  1  1 = count up (taken), 0 = count down (not taken)
//   cnt_next out 2  saturated next value
module sat_counter2
   import gshare_predictor_pkg::*;
(
   input  logic [1:0] cnt,
   input  logic       inc,
   output logic [1:0] cnt_next
);

   always_comb begin
      cnt_next = cnt;
      if (inc) begin
         if (cnt != ST) cnt_next = cnt + 2'd1;
      end else begin
         if (cnt != SNT) cnt_next = cnt - 2'd1;
      end
   end

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor
//   A BTB with valid, tag and target per entry, paired with a gshare BHT of
//   2-bit counters. The BHT is indexed by the PC index XOR the global
//   history. Lookup is combinational. The GHR is updated speculatively on
//   BTB hits and is restored from the resolved branch's snapshot on a
//   mispredict. Training writes take effect on the clock edge, so a lookup
//   in the same cycle as a training write sees the old contents.
// Ports:
//   clk               in   1         rising-edge clock
//   reset             in   1         asynchronous, active-low reset
//   lookup_valid      in   1         IF stage advances this cycle
//   lookup_pc         in   XLEN      IF-stage PC
//   pred_taken        out  1         predicted taken
//   pred_target       out  XLEN      predicted next PC
//   lookup_ghr        out  GHR_BITS  GHR snapshot carried with the instruction
//   update_valid      in   1         resolved branch/jump report from EX
//   update_pc         in   XLEN      PC of the resolved instruction
//   update_ghr        in   GHR_BITS  GHR it was predicted with
//   update_taken      in   1         actual outcome
//   update_target     in   XLEN      actual target
//   update_mispredict in   1         prediction was wrong
module gshare_predictor
   import gshare_predictor_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEFAULT,
   parameter int unsigned IDX_BITS = IDX_BITS_DEFAULT,
   parameter int unsigned GHR_BITS = GHR_BITS_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                lookup_valid,
   input  logic [XLEN-1:0]     lookup_pc,
   output logic                pred_taken,
   output logic [XLEN-1:0]     pred_target,
   output logic [GHR_BITS-1:0] lookup_ghr,
   input  logic                update_valid,
   input  logic [XLEN-1:0]     update_pc,
   input  logic [GHR_BITS-1:0] update_ghr,
   input  logic                update_taken,
   input  logic [XLEN-1:0]     update_target,
   input  logic                update_mispredict
);

   localparam int unsigned DEPTH    = 1 << IDX_BITS;
   localparam int unsigned TAG_BITS = XLEN - IDX_BITS - 2;

   typedef logic [IDX_BITS-1:0] idx_t;

   logic                btb_valid  [DEPTH];
   logic [TAG_BITS-1:0] btb_tag    [DEPTH];
   logic [XLEN-1:0]     btb_target [DEPTH];
   logic [1:0]          bht        [DEPTH];
   logic [GHR_BITS-1:0] ghr;

   idx_t       lk_idx;
   idx_t       lk_bht_idx;
   logic       lk_hit;
   idx_t       up_idx;
   idx_t       up_bht_idx;
   logic [1:0] ctr_next;
   logic       unused_pc_bits;

   // Instructions are word aligned, so the low two PC bits carry no information.
   always_comb unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

   // Lookup path. The GHR is zero-extended to the index width before the XOR.
   always_comb begin
      lk_idx      = lookup_pc[IDX_BITS+1:2];
      lk_bht_idx  = lk_idx ^ idx_t'(ghr);
      lk_hit      = btb_valid[lk_idx] &&
                    (btb_tag[lk_idx] == lookup_pc[XLEN-1:IDX_BITS+2]);
      pred_taken  = lk_hit && bht[lk_bht_idx][1];
      pred_target = pred_taken ? btb_target[lk_idx] : lookup_pc + XLEN'(4);
      lookup_ghr  = ghr;
   end

   always_comb begin
      up_idx     = update_pc[IDX_BITS+1:2];
      up_bht_idx = up_idx ^ idx_t'(update_ghr);
   end

   sat_counter2 u_ctr (
      .cnt      (bht[up_bht_idx]),
      .inc      (update_taken),
      .cnt_next (ctr_next)
   );

   // Mispredict recovery overrides the speculative shift in the same cycle.
   // The casts keep the low GHR_BITS bits of {history, new outcome}.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ghr <= '0;
      end else if (update_valid && update_mispredict) begin
         ghr <= GHR_BITS'({update_ghr, update_taken});
      end else if (lookup_valid && lk_hit) begin
         ghr <= GHR_BITS'({ghr, pred_taken});
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            btb_valid[idx_t'(i)] <= 1'b0;
            bht[idx_t'(i)]       <= WNT;
         end
      end else if (update_valid) begin
         bht[up_bht_idx] <= ctr_next;
         if (update_taken) btb_valid[up_idx] <= 1'b1;
      end
   end

   // Tag and target have no reset because a cleared valid bit masks them.
   always_ff @(posedge clk) begin
      if (update_valid && update_taken) begin
         btb_tag[up_idx]    <= update_pc[XLEN-1:IDX_BITS+2];
         btb_target[up_idx] <= update_target;
      end
   end

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor
//   Self-checking bench for gshare_predictor with default parameters.
//   It applies a directed vector table, then a hand-written asynchronous
//   reset sequence, then random traffic checked against an array-based
//   reference model.
module tb_gshare_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic        lookup_valid;
   logic [31:0] lookup_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [4:0]  lookup_ghr;
   logic        update_valid;
   logic [31:0] update_pc;
   logic [4:0]  update_ghr;
   logic        update_taken;
   logic [31:0] update_target;
   logic        update_mispredict;

   int n_checks = 0;
   int n_fail   = 0;

   gshare_predictor #(.XLEN(32), .IDX_BITS(5), .GHR_BITS(5)) dut (
      .clk               (clk),
      .reset             (reset),
      .lookup_valid      (lookup_valid),
      .lookup_pc         (lookup_pc),
      .pred_taken        (pred_taken),
      .pred_target       (pred_target),
      .lookup_ghr        (lookup_ghr),
      .update_valid      (update_valid),
      .update_pc         (update_pc),
      .update_ghr        (update_ghr),
      .update_taken      (update_taken),
      .update_target     (update_target),
      .update_mispredict (update_mispredict)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference model: plain arrays, with indices computed arithmetically.
   bit          m_valid [32];
   int unsigned m_tag   [32];
   logic [31:0] m_tgt   [32];
   int          m_ctr   [32];
   int unsigned m_ghr;

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 1;
      end
      m_ghr = 0;
   endfunction

   function automatic int unsigned pc_idx(logic [31:0] pc);
      return (pc / 4) % 32;
   endfunction

   function automatic bit m_hit(logic [31:0] pc);
      int unsigned i = pc_idx(pc);
      return m_valid[i] && (m_tag[i] == pc / 128);
   endfunction

   function automatic bit m_taken(logic [31:0] pc);
      return m_hit(pc) && (m_ctr[pc_idx(pc) ^ m_ghr] >= 2);
   endfunction

   function automatic logic [31:0] m_target(logic [31:0] pc);
      return m_taken(pc) ? m_tgt[pc_idx(pc)] : pc + 32'd4;
   endfunction

   // Advances the model by one clock edge using the inputs currently driven.
   function automatic void model_step();
      bit          t   = m_taken(lookup_pc);
      bit          h   = m_hit(lookup_pc);
      int unsigned bi  = pc_idx(update_pc) ^ int'(update_ghr);
      int unsigned ui  = pc_idx(update_pc);
      if (update_valid && update_mispredict)
         m_ghr = (int'(update_ghr) * 2 + int'(update_taken)) % 32;
      else if (lookup_valid && h)
         m_ghr = (m_ghr * 2 + int'(t)) % 32;
      if (update_valid) begin
         if (update_taken) m_ctr[bi] = (m_ctr[bi] == 3) ? 3 : m_ctr[bi] + 1;
         else              m_ctr[bi] = (m_ctr[bi] == 0) ? 0 : m_ctr[bi] - 1;
         if (update_taken) begin
            m_valid[ui] = 1'b1;
            m_tag[ui]   = update_pc / 128;
            m_tgt[ui]   = update_target;
         end
      end
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %0s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   typedef struct {
      logic        lv;
      logic [31:0] lpc;
      logic        uv;
      logic [31:0] upc;
      logic [4:0]  ughr;
      logic        ut;
      logic [31:0] utgt;
      logic        ump;
      logic        e_taken;
      logic [31:0] e_target;
      logic [4:0]  e_ghr;
   } vec_t;

   function automatic vec_t mk(logic lv, logic [31:0] lpc, logic uv, logic [31:0] upc,
                               logic [4:0] ughr, logic ut, logic [31:0] utgt, logic ump,
                               logic et, logic [31:0] etg, logic [4:0] eg);
      vec_t v;
      v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ughr = ughr; v.ut = ut;
      v.utgt = utgt; v.ump = ump; v.e_taken = et; v.e_target = etg; v.e_ghr = eg;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      lookup_valid      = v.lv;
      lookup_pc         = v.lpc;
      update_valid      = v.uv;
      update_pc         = v.upc;
      update_ghr        = v.ughr;
      update_taken      = v.ut;
      update_target     = v.utgt;
      update_mispredict = v.ump;
   endtask

   task automatic cycle_end();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   vec_t vecs[14];

   initial begin
      // Columns: lv, lpc, uv, upc, ughr, ut, utgt, ump | exp taken, target, ghr
      vecs[0]  = mk(1, 32'h100,  0, 32'h0,   5'd0,  0, 32'h0,  0,  0, 32'h104,  5'd0);
      vecs[1]  = mk(0, 32'h100,  1, 32'h100, 5'd0,  1, 32'h40, 1,  0, 32'h104,  5'd0);
      vecs[2]  = mk(0, 32'h100,  0, 32'h0,   5'd0,  0, 32'h0,  0,  0, 32'h104,  5'd1);
      vecs[3]  = mk(0, 32'h100,  1, 32'h100, 5'd0,  1, 32'h40, 0,  0, 32'h104,  5'd1);
      vecs[4]  = mk(0, 32'h100,  1, 32'h100, 5'd0,  1, 32'h40, 0,  0, 32'h104,  5'd1);
      vecs[5]  = mk(0, 32'h100,  1, 32'h100, 5'd0,  1, 32'h40, 0,  0, 32'h104,  5'd1);
      vecs[6]  = mk(0, 32'h100,  1, 32'h104, 5'd0,  0, 32'h0,  1,  0, 32'h104,  5'd1);
      vecs[7]  = mk(0, 32'h100,  0, 32'h0,   5'd0,  0, 32'h0,  0,  1, 32'h40,   5'd0);
      vecs[8]  = mk(0, 32'h100,  1, 32'h100, 5'd0,  0, 32'h0,  0,  1, 32'h40,   5'd0);
      vecs[9]  = mk(0, 32'h100,  0, 32'h0,   5'd0,  0, 32'h0,  0,  1, 32'h40,   5'd0);
      vecs[10] = mk(1, 32'h100,  1, 32'h108, 5'd6,  0, 32'h0,  1,  1, 32'h40,   5'd0);
      vecs[11] = mk(0, 32'h100,  0, 32'h0,   5'd0,  0, 32'h0,  0,  0, 32'h104,  5'd12);
      vecs[12] = mk(1, 32'h1100, 0, 32'h0,   5'd0,  0, 32'h0,  0,  0, 32'h1104, 5'd12);
      vecs[13] = mk(0, 32'h1100, 0, 32'h0,   5'd0,  0, 32'h0,  0,  0, 32'h1104, 5'd12);

      reset = 1'b0;
      drive(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      model_reset();
      #1;
      check("in_reset_taken",  {31'd0, pred_taken}, 32'd0);
      check("in_reset_target", pred_target, 32'h104);
      check("in_reset_ghr",    {27'd0, lookup_ghr}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i]);
         #1;
         check($sformatf("vec%0d_taken", i),  {31'd0, pred_taken}, {31'd0, vecs[i].e_taken});
         check($sformatf("vec%0d_target", i), pred_target, vecs[i].e_target);
         check($sformatf("vec%0d_ghr", i),    {27'd0, lookup_ghr}, {27'd0, vecs[i].e_ghr});
         cycle_end();
      end

      // Bring the GHR back to 0 so that 0x100 predicts taken again.
      drive(mk(0, 32'h100, 1, 32'h104, 5'd0, 0, 32'h0, 1, 0, 0, 0));
      cycle_end();
      drive(mk(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      check("pre_async_taken", {31'd0, pred_taken}, 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check("async_rst_taken",  {31'd0, pred_taken}, 32'd0);
      check("async_rst_target", pred_target, 32'h104);
      check("async_rst_ghr",    {27'd0, lookup_ghr}, 32'd0);
      #1;
      reset = 1'b1;
      model_reset();
      cycle_end();

      // Every BTB entry must be invalid after the reset.
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < 32; i++) begin
            lookup_pc = 32'(t * 128 + i * 4);
            #1;
            check("post_rst_invalid", {31'd0, pred_taken}, 32'd0);
         end
      end
      cycle_end();

      for (int n = 0; n < 500; n++) begin
         lookup_valid      = ($urandom % 4) != 0;
         lookup_pc         = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 31) << 2);
         update_valid      = $urandom % 2;
         update_pc         = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 31) << 2);
         update_ghr        = 5'($urandom);
         update_taken      = ($urandom % 10) < 6;
         update_target     = $urandom & 32'hFFFF_FFFC;
         update_mispredict = ($urandom % 4) == 0;
         #1;
         check("rnd_taken",  {31'd0, pred_taken}, {31'd0, m_taken(lookup_pc)});
         check("rnd_target", pred_target, m_target(lookup_pc));
         check("rnd_ghr",    {27'd0, lookup_ghr}, m_ghr);
         cycle_end();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
